// File: rtl/hdcpu_seq.sv
// Hard-wired control sequencer: HALT/RUN beats W1..W3, console modes and run decode.
// Optional interrupt support is enabled by defining HDCPU_SEQ_INT_EN.
module hdcpu_seq #(
  parameter int NREG = 4,
  parameter int CONSOLE_STEP = 2,
  localparam int RSEL_W = $clog2(NREG)
) (
  input  logic              T3,
  input  logic              CLR,
  input  logic [2:0]        SW,
  input  logic              PULSE,
  input  logic [3:0]        IR,
  input  logic              C,
  input  logic              Z,
`ifdef HDCPU_SEQ_INT_EN
  input  logic              INTR,
  output logic              INTA,
`endif
  output logic [3:1]        W,
  output logic              EXEC,
  output logic              ST0,
  output logic [RSEL_W-1:0] SELA,
  output logic [RSEL_W-1:0] SELB,
  output logic [3:0]        S,
  output logic              SELCTL,
  output logic              LDC,
  output logic              LDZ,
  output logic              CIN,
  output logic              M,
  output logic              ABUS,
  output logic              DRW,
  output logic              PCINC,
  output logic              LPC,
  output logic              LAR,
  output logic              PCADD,
  output logic              ARINC,
  output logic              MEMW,
  output logic              LIR,
  output logic              SBUS,
  output logic              MBUS
);

  logic              run;
  logic [3:1]        w_q;
  logic              st0_q;
  logic [RSEL_W-1:0] idx_q;
  logic [2:0]        sw_q;

  logic              sw_chg;
  logic              st0_eff;
  logic [RSEL_W-1:0] idx_eff;
  logic [2:0]        mode;

  logic [3:0]        d_s;
  logic              d_m, d_cin, d_selctl;
  logic [RSEL_W-1:0] d_sela, d_selb;
  logic              d_ldc, d_ldz, d_abus, d_drw, d_pcinc;
  logic              d_lpc, d_lar, d_pcadd, d_arinc, d_memw;
  logic              d_lir, d_sbus, d_mbus;
  logic              short_b, long_b, stop;
  logic              st0_nxt;
  logic [RSEL_W-1:0] idx_nxt;
  logic [3:1]        w_nxt;

`ifdef HDCPU_SEQ_INT_EN
  logic ien_q, intp_q, ien_nxt;
  logic int_beat, ien_set;
`endif

  // A new console mode starts from a clean phase/index
  assign sw_chg  = run && w_q[1] && (SW != sw_q);
  assign st0_eff = sw_chg ? 1'b0 : st0_q;
  assign idx_eff = sw_chg ? '0 : idx_q;
  assign mode    = w_q[1] ? SW : sw_q;

  always_comb begin
    d_s = 4'b0000;
    d_m = 1'b0;
    d_cin = 1'b0;
    d_selctl = 1'b0;
    d_sela = '0;
    d_selb = '0;
    d_ldc = 1'b0;
    d_ldz = 1'b0;
    d_abus = 1'b0;
    d_drw = 1'b0;
    d_pcinc = 1'b0;
    d_lpc = 1'b0;
    d_lar = 1'b0;
    d_pcadd = 1'b0;
    d_arinc = 1'b0;
    d_memw = 1'b0;
    d_lir = 1'b0;
    d_sbus = 1'b0;
    d_mbus = 1'b0;
    short_b = 1'b0;
    long_b = 1'b0;
    stop = 1'b0;
    st0_nxt = st0_eff;
    idx_nxt = idx_eff;
`ifdef HDCPU_SEQ_INT_EN
    int_beat = 1'b0;
    ien_set = 1'b0;
`endif
    unique case (mode)
      3'b001: begin
        d_selctl = 1'b1;
        d_sbus = 1'b1;
        short_b = 1'b1;
        stop = 1'b1;
        if (!st0_eff) begin
          d_lar = 1'b1;
          st0_nxt = 1'b1;
        end else begin
          d_memw = 1'b1;
          d_arinc = 1'b1;
        end
      end
      3'b010: begin
        d_selctl = 1'b1;
        short_b = 1'b1;
        stop = 1'b1;
        if (!st0_eff) begin
          d_sbus = 1'b1;
          d_lar = 1'b1;
          st0_nxt = 1'b1;
        end else begin
          d_mbus = 1'b1;
          d_arinc = 1'b1;
        end
      end
      3'b011: begin
        d_selctl = 1'b1;
        short_b = 1'b1;
        stop = 1'b1;
        d_sela = idx_eff;
        d_selb = idx_eff + RSEL_W'(1);
        idx_nxt = idx_eff + RSEL_W'(CONSOLE_STEP);
      end
      3'b100: begin
        d_selctl = 1'b1;
        short_b = 1'b1;
        stop = 1'b1;
        d_sbus = 1'b1;
        d_drw = 1'b1;
        d_selb = idx_eff;
        idx_nxt = idx_eff + RSEL_W'(1);
        if (idx_nxt == '0) st0_nxt = 1'b1;
      end
      3'b000: begin
        unique case (1'b1)
          w_q[1]: begin
`ifdef HDCPU_SEQ_INT_EN
            if (intp_q) begin
              int_beat = 1'b1;
              d_lpc = 1'b1;
              d_m = 1'b1;
              d_s = 4'b1111;
              short_b = 1'b1;
            end else begin
              d_lir = 1'b1;
              d_pcinc = 1'b1;
            end
`else
            d_lir = 1'b1;
            d_pcinc = 1'b1;
`endif
          end
          w_q[2]: begin
            unique case (IR)
              4'h1: begin
                d_s = 4'b1001;
                d_cin = 1'b1;
                d_abus = 1'b1;
                d_drw = 1'b1;
                d_ldz = 1'b1;
                d_ldc = 1'b1;
              end
              4'h2: begin
                d_s = 4'b0110;
                d_abus = 1'b1;
                d_drw = 1'b1;
                d_ldz = 1'b1;
                d_ldc = 1'b1;
              end
              4'h3: begin
                d_m = 1'b1;
                d_s = 4'b1011;
                d_abus = 1'b1;
                d_drw = 1'b1;
                d_ldz = 1'b1;
              end
              4'h4: begin
                d_abus = 1'b1;
                d_drw = 1'b1;
                d_ldz = 1'b1;
                d_ldc = 1'b1;
              end
              4'h5: begin
                d_m = 1'b1;
                d_s = 4'b1010;
                d_abus = 1'b1;
                d_lar = 1'b1;
                long_b = 1'b1;
              end
              4'h6: begin
                d_m = 1'b1;
                d_s = 4'b1111;
                d_abus = 1'b1;
                d_lar = 1'b1;
                long_b = 1'b1;
              end
              4'h7: d_pcadd = C;
              4'h8: d_pcadd = Z;
              4'h9: begin
                d_m = 1'b1;
                d_s = 4'b1111;
                d_abus = 1'b1;
                d_lpc = 1'b1;
              end
              4'hA: begin
                d_m = 1'b1;
                d_s = 4'b1010;
                d_abus = 1'b1;
              end
              4'hB: begin
                d_m = 1'b1;
                d_s = 4'b0110;
                d_abus = 1'b1;
                d_drw = 1'b1;
                d_ldz = 1'b1;
              end
              4'hC: begin
                d_m = 1'b1;
                d_s = 4'b1110;
                d_abus = 1'b1;
                d_drw = 1'b1;
                d_ldz = 1'b1;
              end
`ifdef HDCPU_SEQ_INT_EN
              4'hD: ien_set = 1'b1;
`endif
              4'hE: stop = 1'b1;
              default: ;
            endcase
          end
          w_q[3]: begin
            if (IR == 4'h5) begin
              d_drw = 1'b1;
              d_mbus = 1'b1;
            end else if (IR == 4'h6) begin
              d_m = 1'b1;
              d_s = 4'b1010;
              d_abus = 1'b1;
              d_memw = 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: begin
        short_b = 1'b1;
        stop = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_nxt = 3'b001;
    if (w_q[1] && !short_b) w_nxt = 3'b010;
    if (w_q[2] && long_b) w_nxt = 3'b100;
  end

`ifdef HDCPU_SEQ_INT_EN
  assign ien_nxt = int_beat ? 1'b0 : (ien_set ? 1'b1 : ien_q);
`endif

  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      run   <= 1'b0;
      w_q   <= 3'b001;
      st0_q <= 1'b0;
      idx_q <= '0;
      sw_q  <= 3'b000;
`ifdef HDCPU_SEQ_INT_EN
      ien_q  <= 1'b1;
      intp_q <= 1'b0;
`endif
    end else if (!run) begin
      if (PULSE) run <= 1'b1;
    end else begin
      w_q   <= w_nxt;
      st0_q <= st0_nxt;
      idx_q <= idx_nxt;
      if (w_q[1]) sw_q <= SW;
      if (stop) run <= 1'b0;
`ifdef HDCPU_SEQ_INT_EN
      ien_q  <= ien_nxt;
      intp_q <= w_nxt[1] && (mode == 3'b000) && INTR && ien_nxt && !stop;
`endif
    end
  end

  assign W      = w_q;
  assign EXEC   = run;
  assign ST0    = st0_eff;
  assign SELA   = run ? d_sela : '0;
  assign SELB   = run ? d_selb : '0;
  assign S      = run ? d_s : 4'b0000;
  assign M      = run & d_m;
  assign CIN    = run & d_cin;
  assign SELCTL = run & d_selctl;
  assign LDC    = run & d_ldc;
  assign LDZ    = run & d_ldz;
  assign ABUS   = run & d_abus;
  assign DRW    = run & d_drw;
  assign PCINC  = run & d_pcinc;
  assign LPC    = run & d_lpc;
  assign LAR    = run & d_lar;
  assign PCADD  = run & d_pcadd;
  assign ARINC  = run & d_arinc;
  assign MEMW   = run & d_memw;
  assign LIR    = run & d_lir;
  assign SBUS   = run & d_sbus;
  assign MBUS   = run & d_mbus;
`ifdef HDCPU_SEQ_INT_EN
  assign INTA   = run & int_beat;
`endif

endmodule
